// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - write-through set-associative cache with tree-PLRU replacement
// Optional CACHE_WRITE_ALLOCATE_EN: store misses refill the line before writing through.
module set_assoc_cache #(
  parameter int WAYS        = 4,
  parameter int SETS        = 8,
  parameter int BLOCK_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_valid_i,
  output logic                     cpu_ready_o,
  input  logic                     cpu_wen_i,
  input  logic [31:0]              cpu_addr_i,
  input  logic [2:0]               cpu_funct3_i,
  input  logic [31:0]              cpu_wdata_i,
  output logic                     cpu_done_o,
  output logic [31:0]              cpu_rdata_o,
  output logic                     mem_valid_o,
  output logic                     mem_wen_o,
  output logic [31:0]              mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  output logic [3:0]               mem_wstrb_o,
  input  logic                     mem_ready_i,
  input  logic [BLOCK_BYTES*8-1:0] mem_rdata_i
);

  localparam int BW     = BLOCK_BYTES * 8;
  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int LVL    = $clog2(WAYS);
  localparam int WAY_W  = (WAYS > 1) ? LVL : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, WRITEMEM} state_t;

`ifdef CACHE_WRITE_ALLOCATE_EN
  localparam state_t STORE_MISS_NEXT = REFILL;
`else
  localparam state_t STORE_MISS_NEXT = WRITEMEM;
`endif

  state_t state_q, state_d;

  logic        req_wen_q;
  logic [31:0] req_addr_q;
  logic [2:0]  req_f3_q;
  logic [31:0] req_wdata_q;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [PLRU_W-1:0] plru_q  [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [BW-1:0]     data_q  [SETS][WAYS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [OFF_W+2:0]  line_sh;

  assign idx     = req_addr_q[OFF_W +: IDX_W];
  assign tag     = req_addr_q[31 -: TAG_W];
  assign line_sh = {req_addr_q[OFF_W-1:0] & ~OFF_W'(3), 3'b000};

  logic              hit, has_inv;
  logic [WAY_W-1:0]  hit_way, inv_way, victim;
  logic [PLRU_W-1:0] plru_upd;
  int                vnode, unode, dir;

  // Descending scan so the lowest matching / lowest invalid way is the one that sticks.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  // Tree walk: a node bit of 0 sends the victim left, 1 sends it right.
  always_comb begin
    vnode = 1;
    for (int l = 0; l < LVL; l++)
      vnode = 2 * vnode + (int'(plru_q[idx] >> (vnode - 1)) & 1);
    victim = has_inv ? inv_way : WAY_W'(vnode - WAYS);
  end

  always_comb begin
    plru_upd = plru_q[idx];
    unode    = 1;
    dir      = 0;
    for (int l = 0; l < LVL; l++) begin
      dir      = int'(hit_way >> (LVL - 1 - l)) & 1;
      plru_upd = (plru_upd & ~(PLRU_W'(1) << (unode - 1))) | (PLRU_W'(1 - dir) << (unode - 1));
      unode    = 2 * unode + dir;
    end
  end

  logic [BW-1:0] hit_line, line_mask, merged;
  logic [31:0]   rword, load_data, lane_data, lane_mask;
  logic [3:0]    lane_strb;
  logic [7:0]    bsel;
  logic [15:0]   hsel;

  assign hit_line = data_q[idx][hit_way];
  assign rword    = 32'(hit_line >> line_sh);

  always_comb begin
    lane_data = req_wdata_q;
    lane_strb = 4'b1111;
    load_data = rword;
    bsel      = '0;
    hsel      = '0;
    case (req_f3_q[1:0])
      2'b00: begin
        lane_data = {24'b0, req_wdata_q[7:0]} << {req_addr_q[1:0], 3'b000};
        lane_strb = 4'b0001 << req_addr_q[1:0];
        bsel      = 8'(rword >> {req_addr_q[1:0], 3'b000});
        load_data = {{24{bsel[7] & ~req_f3_q[2]}}, bsel};
      end
      2'b01: begin
        lane_data = {16'b0, req_wdata_q[15:0]} << {req_addr_q[1], 4'b0000};
        lane_strb = 4'b0011 << {req_addr_q[1], 1'b0};
        hsel      = 16'(rword >> {req_addr_q[1], 4'b0000});
        load_data = {{16{hsel[15] & ~req_f3_q[2]}}, hsel};
      end
      default: ;
    endcase
  end

  assign lane_mask = {{8{lane_strb[3]}}, {8{lane_strb[2]}}, {8{lane_strb[1]}}, {8{lane_strb[0]}}};
  assign line_mask = BW'(lane_mask) << line_sh;
  assign merged    = (hit_line & ~line_mask) | ((BW'(lane_data) << line_sh) & line_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_f3_q    <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cpu_valid_i) begin
        req_wen_q   <= cpu_wen_i;
        req_addr_q  <= cpu_addr_i;
        req_f3_q    <= cpu_funct3_i;
        req_wdata_q <= cpu_wdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cpu_valid_i) state_d = LOOKUP;
      LOOKUP: begin
        if (hit)             state_d = req_wen_q ? WRITEMEM : IDLE;
        else if (!req_wen_q) state_d = REFILL;
        else                 state_d = STORE_MISS_NEXT;
      end
      REFILL:   if (mem_ready_i) state_d = LOOKUP;
      WRITEMEM: if (mem_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready_o = (state_q == IDLE);
    cpu_done_o  = 1'b0;
    cpu_rdata_o = '0;
    mem_valid_o = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    case (state_q)
      LOOKUP: if (hit && !req_wen_q) begin
        cpu_done_o  = 1'b1;
        cpu_rdata_o = load_data;
      end
      REFILL: begin
        mem_valid_o = 1'b1;
        mem_addr_o  = {req_addr_q[31:OFF_W], {OFF_W{1'b0}}};
      end
      WRITEMEM: begin
        mem_valid_o = 1'b1;
        mem_wen_o   = 1'b1;
        mem_addr_o  = {req_addr_q[31:2], 2'b00};
        mem_wdata_o = lane_data;
        mem_wstrb_o = lane_strb;
        cpu_done_o  = mem_ready_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (state_q == REFILL && mem_ready_i) valid_q[idx][victim] <= 1'b1;
      if (state_q == LOOKUP && hit)         plru_q[idx]          <= plru_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == REFILL && mem_ready_i) begin
      tag_q[idx][victim]  <= tag;
      data_q[idx][victim] <= mem_rdata_i;
    end else if (state_q == LOOKUP && hit && req_wen_q) begin
      data_q[idx][hit_way] <= merged;
    end
  end

endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity (1, 2, 4 or 8).
REQ-002 SHALL have parameter SETS, default 8, set count (power of 2, ≥2).
REQ-003 SHALL have parameter BLOCK_BYTES, default 16, line size in bytes (power of 2, ≥4); BW = BLOCK_BYTES*8.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port cpu_valid_i, input, 1, CPU request valid.
REQ-007 SHALL have port cpu_ready_o, output, 1, cache can accept a request.
REQ-008 SHALL have port cpu_wen_i, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port cpu_addr_i, input, 32, byte address split as tag | index (log2 SETS) | offset (log2 BLOCK_BYTES).
REQ-010 SHALL have port cpu_funct3_i, input, 3, RV32 load/store size code.
REQ-011 SHALL have port cpu_wdata_i, input, 32, store data, LSB-aligned.
REQ-012 SHALL have port cpu_done_o, output, 1, one-cycle request-complete pulse.
REQ-013 SHALL have port cpu_rdata_o, output, 32, load result, extended per funct3.
REQ-014 SHALL have port mem_valid_o, output, 1, memory request valid.
REQ-015 SHALL have port mem_wen_o, output, 1, 1 = word write, 0 = block read.
REQ-016 SHALL have port mem_addr_o, output, 32, block-aligned for reads, word-aligned for writes.
REQ-017 SHALL have port mem_wdata_o, output, 32, write word, lane-aligned.
REQ-018 SHALL have port mem_wstrb_o, output, 4, byte strobes for write.
REQ-019 SHALL have port mem_ready_i, input, 1, memory completes current request.
REQ-020 SHALL have port mem_rdata_i, input, BW, refill block; byte 0 in bits [7:0].

Function
REQ-021 SHALL implement FSM states IDLE, LOOKUP, REFILL, WRITEMEM; cpu_ready_o = 1 only in IDLE; handshake cpu_valid_i & cpu_ready_o latches wen/addr/funct3/wdata and moves to LOOKUP.
REQ-022 LOOKUP SHALL compare the tag against all valid ways of the indexed set; on multiple matches the lowest way index wins.
REQ-023 Load hit in LOOKUP SHALL assert cpu_done_o with cpu_rdata_o that same cycle (done in the cycle after acceptance), update PLRU, then go to IDLE.
REQ-024 Load miss SHALL go to REFILL, with mem_valid_o=1, mem_wen_o=0 and the block-aligned address.
REQ-025 On mem_ready_i in REFILL the cache SHALL write the block into the victim way, set valid, write the tag, and return to LOOKUP, which then hits.
REQ-026 Victim selection SHALL take the lowest-index invalid way if any exists; otherwise the tree-PLRU way (WAYS-1 bits per set).
REQ-027 On every hit the PLRU bits SHALL be updated to point away from the accessed way; with WAYS=1 there are no PLRU bits and the victim is always way 0.
REQ-028 Store hit SHALL merge the bytes selected by wstrb into the line during LOOKUP, update PLRU, and go to WRITEMEM (write-through).
REQ-029 WRITEMEM SHALL drive mem_valid_o=1, mem_wen_o=1, addr = {addr[31:2],2'b00}, and lane-shifted data/strobes; cpu_done_o SHALL be asserted in the cycle mem_ready_i=1, then the FSM goes to IDLE.
REQ-030 All mem_* outputs SHALL stay stable while mem_valid_o=1 and mem_ready_i=0; mem_valid_o SHALL be 0 in IDLE and LOOKUP.
REQ-031 funct3 decode: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; low bits [1:0]=11 SHALL be treated as word; lb/lh SHALL sign-extend and lbu/lhu SHALL zero-extend.
REQ-032 Accesses SHALL be treated as naturally aligned: halfword ignores addr[0], word ignores addr[1:0].
REQ-033 cpu_rdata_o SHALL be 0 whenever cpu_done_o=0; cpu_valid_i SHALL be ignored when cpu_ready_o=0.

Reset
REQ-034 While rst_n=0: state IDLE, all valid bits 0, PLRU bits 0, cpu_done_o=0, mem_valid_o=0, mem_wen_o=0, cpu_ready_o=1; assertion mid-transaction SHALL abort immediately (no memory handshake completes); tag/data arrays need no reset.

Configuration
REQ-035 Macro CACHE_WRITE_ALLOCATE_EN defined: a store miss SHALL go REFILL → LOOKUP (hit, merge) → WRITEMEM.
REQ-036 Macro CACHE_WRITE_ALLOCATE_EN undefined: a store miss SHALL go directly to WRITEMEM, with the cache arrays and PLRU unchanged.

Verification (WAYS=4, SETS=8, BLOCK_BYTES=16)
REQ-037 After reset, lw 0x40, mem returns word0=0xDEADBEEF after 3 wait cycles -> one block read at 0x40, done with 0xDEADBEEF; repeat lw 0x40 -> done 1 cycle after accept, no mem_valid_o.
REQ-038 Block at 0x40 with byte3=0x80, bytes[3:2]=0x8001: lb 0x43 -> 0xFFFFFF80, lbu 0x43 -> 0x00000080, lh 0x42 -> 0xFFFF8001, lhu 0x42 -> 0x00008001.
REQ-039 Loads 0x000, 0x080, 0x100, 0x180 (set 0, ways 0-3), then 0x000 hit, then 0x200 miss -> victim way 2; then 0x100 misses and 0x000 hits.
REQ-040 sh 0x46 data 0x1234 on a hit -> mem write addr 0x44, wstrb 0b1100, wdata 0x12340000; next lw 0x44 hits with [31:16]=0x1234.
REQ-041 sw 0x300 0xCAFEF00D on a miss: with the macro -> block read at 0x300, then word write, then lw 0x300 hits 0xCAFEF00D; without the macro -> single write, and lw 0x300 misses.
REQ-042 rst_n low while in REFILL with mem_ready_i=0 -> mem_valid_o drops at once, cpu_ready_o=1 after release, and a prior-hit address misses.
